// File: rtl/weight_stream_ctrl_pkg.sv
// Shared sizing constants and helpers for the layer weight streamer.
package weight_stream_ctrl_pkg;

  // Local copies of the layer sizing macros (3x3x32 kernel, 16-bit coefficients).
  localparam int KERN_S_16   = 288;
  localparam int COEFF_WIDTH = 16;
  localparam int PASS_WIDTH  = 16;
  localparam int SKID_DEPTH  = 3;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_stream_ctrl_if.sv
// ROM read port and weight FIFO write port of the weight streamer.
interface weight_stream_ctrl_if
  import weight_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = COEFF_WIDTH,
  parameter int ADDR_WIDTH = addr_bits(KERN_S_16)
);
  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] output_V_din;
  logic                  output_V_full_n;
  logic                  output_V_write;

  modport master (
    output rom_address, rom_ce, output_V_din, output_V_write,
    input  rom_q, output_V_full_n
  );

  modport slave (
    input  rom_address, rom_ce, output_V_din, output_V_write,
    output rom_q, output_V_full_n
  );
endinterface

// File: rtl/weight_stream_ctrl_skid_fifo.sv
// Three-entry register FIFO that absorbs the ROM read latency; entry 0 is always the head.
module weight_skid_fifo
  import weight_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = COEFF_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] entry_reg [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] shift_in  [SKID_DEPTH];
  logic [1:0]            count_reg, count_next;
  logic [1:0]            fill_slot;
  logic                  pop_ok;

  assign pop_ok     = pop && (count_reg != 2'd0);
  // A simultaneous pop shifts everything down, so the new word lands one slot lower.
  assign fill_slot  = pop_ok ? (count_reg - 2'd1) : count_reg;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop_ok};

  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    if (gi < SKID_DEPTH - 1) begin : g_shift
      assign shift_in[gi] = entry_reg[gi+1];
    end else begin : g_tail
      assign shift_in[gi] = entry_reg[gi];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        entry_reg[gi] <= '0;
      end else if (push && (fill_slot == 2'(gi))) begin
        entry_reg[gi] <= push_data;
      end else if (pop_ok) begin
        entry_reg[gi] <= shift_in[gi];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign head  = entry_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/weight_stream_ctrl.sv
// Walks the coefficient ROM cfg_passes times and streams every word into the weight FIFO.
module weight_stream_ctrl
  import weight_stream_ctrl_pkg::*;
#(
  parameter int MEM_SIZE   = KERN_S_16,
  parameter int DATA_WIDTH = COEFF_WIDTH,
  parameter int ADDR_WIDTH = addr_bits(MEM_SIZE)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  output logic                  ap_idle,
  output logic                  ap_done,
  weight_stream_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_ONE  = PASS_WIDTH'(1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [PASS_WIDTH-1:0]   pass_reg, pass_next;
  logic [PASS_WIDTH-1:0]   passes_reg, passes_next;
  logic                    inflight_reg;
  logic                    issue;
  logic                    pop;
  logic                    credit_ok;
  logic [1:0]              count;
  logic [DATA_WIDTH-1:0]   head;

  // Credit uses registered state only, so full_n never reaches rom_ce/rom_address.
  assign credit_ok = ({1'b0, count} + {2'b00, inflight_reg}) < 3'd3;
  assign pop       = (count != 2'd0) && bus.output_V_full_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      pass_reg     <= '0;
      passes_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      pass_reg     <= pass_next;
      passes_reg   <= passes_next;
      inflight_reg <= issue;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    pass_next   = pass_reg;
    passes_next = passes_reg;
    issue       = 1'b0;
    ap_idle     = 1'b0;
    ap_done     = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          passes_next = cfg_passes;
          addr_next   = '0;
          pass_next   = '0;
          state_next  = (cfg_passes == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (addr_reg == LAST_ADDR) begin
            addr_next = '0;
            pass_next = pass_reg + PASS_ONE;
            if (pass_reg == passes_reg - PASS_ONE) begin
              state_next = S_DRAIN;
            end
          end else begin
            addr_next = addr_reg + ADDR_ONE;
          end
        end
      end
      S_DRAIN: begin
        // Leave as the last word is popped so ap_done lands right after the final write.
        if (!inflight_reg && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        ap_done    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  weight_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .push      (inflight_reg),
    .push_data (bus.rom_q),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.rom_ce         = issue;
  assign bus.rom_address    = addr_reg;
  assign bus.output_V_write = pop;
  assign bus.output_V_din   = head;

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Scoreboard bench: three streamers (MEM_SIZE 4, 288, 1) checked against a pass-by-pass ROM walk model.
module tb_weight_stream_ctrl;
  import weight_stream_ctrl_pkg::*;

  localparam int NDUT = 3;
  localparam int DW   = 16;
  localparam int MS [NDUT] = '{4, 288, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n  [NDUT];
  logic        start  [NDUT];
  logic [15:0] passes [NDUT];
  logic        full_n [NDUT];
  logic        idle   [NDUT];
  logic        done   [NDUT];

  weight_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) bus0 ();
  weight_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(9)) bus1 ();
  weight_stream_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(1)) bus2 ();

  weight_stream_ctrl #(.MEM_SIZE(4), .DATA_WIDTH(DW), .ADDR_WIDTH(2)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n[0]), .ap_start(start[0]), .cfg_passes(passes[0]),
    .ap_idle(idle[0]), .ap_done(done[0]), .bus(bus0.master));
  weight_stream_ctrl #(.MEM_SIZE(288), .DATA_WIDTH(DW), .ADDR_WIDTH(9)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n[1]), .ap_start(start[1]), .cfg_passes(passes[1]),
    .ap_idle(idle[1]), .ap_done(done[1]), .bus(bus1.master));
  weight_stream_ctrl #(.MEM_SIZE(1), .DATA_WIDTH(DW), .ADDR_WIDTH(1)) u_dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n[2]), .ap_start(start[2]), .cfg_passes(passes[2]),
    .ap_idle(idle[2]), .ap_done(done[2]), .bus(bus2.master));

  assign bus0.output_V_full_n = full_n[0];
  assign bus1.output_V_full_n = full_n[1];
  assign bus2.output_V_full_n = full_n[2];

  // ROM models: data valid the cycle after rom_ce.
  logic [DW-1:0] rom_mem [NDUT][288];
  always @(posedge clk) if (bus0.rom_ce) bus0.rom_q <= rom_mem[0][int'(bus0.rom_address)];
  always @(posedge clk) if (bus1.rom_ce) bus1.rom_q <= rom_mem[1][int'(bus1.rom_address)];
  always @(posedge clk) if (bus2.rom_ce) bus2.rom_q <= rom_mem[2][int'(bus2.rom_address)];

  // Expectations pushed by stimulus.
  logic [DW-1:0] exp_q    [NDUT][$];
  int            exp_wc_q [NDUT][$];
  int            start_cyc    [NDUT] = '{default: 0};
  int            exp_reads    [NDUT] = '{default: 0};
  int            exp_done_rel [NDUT] = '{default: 0};
  int            hold_from    [NDUT] = '{default: -1};
  int            hold_to      [NDUT] = '{default: -2};
  logic [DW-1:0] hold_val     [NDUT] = '{default: '0};
  int            timeout_cnt = 0;

  // Monitor-owned state.
  int   run_reads   [NDUT] = '{default: 0};
  int   run_writes  [NDUT] = '{default: 0};
  int   last_wr_cyc [NDUT] = '{default: 0};
  logic done_prev   [NDUT] = '{default: 1'b0};
  int   timeouts_seen = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input int k, input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL dut%0d %s: got %0d required %0d (cycle %0d)", k, name, act, req, cyc);
    end
  endtask

  task automatic observe(input int k, input logic wr, input logic [DW-1:0] din,
                         input logic ce, input int addr, input logic idl, input logic dn);
    int rel;
    logic [DW-1:0] exp_w;
    int exp_c;
    rel = cyc - start_cyc[k];
    if (!rst_n[k]) begin
      check(k, "rst_idle", longint'(idl), 1);
      check(k, "rst_done", longint'(dn), 0);
      check(k, "rst_rom_ce", longint'(ce), 0);
      check(k, "rst_rom_address", addr, 0);
      check(k, "rst_write", longint'(wr), 0);
      check(k, "rst_din", longint'(din), 0);
      exp_q[k].delete();
      exp_wc_q[k].delete();
      run_reads[k]  = 0;
      run_writes[k] = 0;
      done_prev[k]  = 1'b0;
      return;
    end
    if (done_prev[k]) check(k, "idle_after_done", longint'(idl), 1);
    done_prev[k] = dn;
    if (ce) begin
      run_reads[k]++;
      if (run_reads[k] - run_writes[k] > 3) check(k, "outstanding_le_3", run_reads[k] - run_writes[k], 3);
      else checks++;
      if (k == 2) check(k, "mem1_address", addr, 0);
    end
    if (wr) begin
      run_writes[k]++;
      last_wr_cyc[k] = cyc;
      if (exp_q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d spurious_write: got din %0h, required no write (cycle %0d)", k, din, cyc);
      end else begin
        exp_w = exp_q[k].pop_front();
        exp_c = exp_wc_q[k].pop_front();
        check(k, "din", longint'(din), longint'(exp_w));
        if (exp_c >= 0) check(k, "write_cycle", rel, exp_c);
      end
    end else if (rel >= hold_from[k] && rel <= hold_to[k]) begin
      check(k, "hold_din", longint'(din), longint'(hold_val[k]));
    end
    if (dn) begin
      if (exp_done_rel[k] >= 0) check(k, "done_cycle", rel, exp_done_rel[k]);
      else check(k, "done_after_last_write", cyc, last_wr_cyc[k] + 1);
      check(k, "words_left", exp_q[k].size(), 0);
      check(k, "rom_reads", run_reads[k], exp_reads[k]);
      $display("dut%0d run done at rel cycle %0d: reads %0d writes %0d", k, rel, run_reads[k], run_writes[k]);
      run_reads[k]  = 0;
      run_writes[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    observe(0, bus0.output_V_write, bus0.output_V_din, bus0.rom_ce, int'(bus0.rom_address), idle[0], done[0]);
    observe(1, bus1.output_V_write, bus1.output_V_din, bus1.rom_ce, int'(bus1.rom_address), idle[1], done[1]);
    observe(2, bus2.output_V_write, bus2.output_V_din, bus2.rom_ce, int'(bus2.rom_address), idle[2], done[2]);
    if (timeout_cnt != timeouts_seen) begin
      check(0, "run_timeout", timeout_cnt, timeouts_seen);
      timeouts_seen = timeout_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: np full walks of the ROM in address order; timed runs write one word per cycle from cycle 3.
  task automatic start_run(input int k, input int np, input bit timed, input int done_rel);
    for (int p = 0; p < np; p++) begin
      for (int a = 0; a < MS[k]; a++) begin
        exp_q[k].push_back(rom_mem[k][a]);
        exp_wc_q[k].push_back(timed ? (3 + p * MS[k] + a) : -1);
      end
    end
    exp_reads[k]    = np * MS[k];
    exp_done_rel[k] = done_rel;
    tick();
    start[k]     = 1'b1;
    passes[k]    = 16'(np);
    start_cyc[k] = cyc;
    tick();
    start[k]  = 1'b0;
    passes[k] = 16'($urandom);
  endtask

  task automatic wait_done(input int k, input int budget, input bit rand_full, input int restart_at);
    int n;
    n = 0;
    while (!done[k] && n < budget) begin
      if (rand_full) full_n[k] = 1'($urandom_range(0, 1));
      start[k] = (n == restart_at);
      if (n == restart_at) passes[k] = 16'd7;
      tick();
      n++;
    end
    if (!done[k]) timeout_cnt++;
    start[k]  = 1'b0;
    full_n[k] = 1'b1;
    tick();
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst_n[k]  = 1'b0;
      start[k]  = 1'b0;
      passes[k] = '0;
      full_n[k] = 1'b1;
      for (int a = 0; a < 288; a++) rom_mem[k][a] = 16'($urandom);
    end
    repeat (3) tick();
    for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;
    tick();

    // MEM_SIZE=4, two passes, no backpressure.
    start_run(0, 2, 1'b1, 11);
    wait_done(0, 50, 1'b0, -1);

    // Same run with full_n low in cycles 4..9; head must hold B.
    hold_from[0] = 4;
    hold_to[0]   = 9;
    hold_val[0]  = rom_mem[0][1];
    start_run(0, 2, 1'b0, -1);
    repeat (3) tick();
    full_n[0] = 1'b0;
    repeat (6) tick();
    full_n[0] = 1'b1;
    wait_done(0, 50, 1'b0, -1);
    hold_from[0] = -1;
    hold_to[0]   = -2;

    // Zero passes: done in cycle 1, no reads, no writes.
    start_run(0, 0, 1'b0, 1);
    wait_done(0, 20, 1'b0, -1);

    // MEM_SIZE=288, three passes, random full_n, stray ap_start mid-run.
    start_run(1, 3, 1'b0, -1);
    wait_done(1, 6000, 1'b1, 100);

    // Reset in pass 2 with words buffered, then a fresh run from address 0.
    start_run(0, 3, 1'b0, -1);
    repeat (5) tick();
    full_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b0;
    repeat (3) tick();
    full_n[0] = 1'b1;
    rst_n[0]  = 1'b1;
    repeat (4) tick();
    start_run(0, 1, 1'b1, 7);
    wait_done(0, 50, 1'b0, -1);

    // MEM_SIZE=1, five passes.
    start_run(2, 5, 1'b1, 8);
    wait_done(2, 50, 1'b0, -1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
